poly_sub_ctrl: RTL and testbench

POLY_SUB_CTRL -- requirements
Module: poly_sub_ctrl

---
 rtl/poly_sub_ctrl_pkg.sv | 28 ++
 rtl/poly_sub_ctrl_coeff.sv | 57 +++++
 rtl/poly_sub_ctrl.sv | 128 ++++++++++++
 tb/tb_poly_sub_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_sub_ctrl_pkg.sv
// Shared definitions for the polynomial subtraction block.
//   NEWHOPE_Q / OFFSET_3Q : modulus and the bias that keeps a - b non-negative
//   N_DEFAULT / AW_DEFAULT: default polynomial length and its address width
//   state_t               : sequencing FSM encoding
//   cond_sub()            : one conditional-subtract step of the modular reducer
package poly_sub_ctrl_pkg;

  localparam int NEWHOPE_Q  = 12289;
  localparam int OFFSET_3Q  = 3 * NEWHOPE_Q;  // 36867
  localparam int N_DEFAULT  = 1024;
  localparam int AW_DEFAULT = 10;

  // a + 3Q - b for a, b < Q stays below 4Q = 49156, so 17 bits suffice.
  localparam int CW = 17;
  typedef logic [CW-1:0] coeff_wide_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  function automatic coeff_wide_t cond_sub(input coeff_wide_t v, input coeff_wide_t k);
    return (v >= k) ? (v - k) : v;
  endfunction

endpackage

// File: rtl/poly_sub_ctrl_coeff.sv
// poly_sub_coeff: pipelined modular subtractor, r = (a - b) mod Q.
//   clk, rst : clock, asynchronous active-high reset
//   start    : dia/dib valid this cycle (one coefficient per cycle, no stalls)
//   dia, dib : operands in [0, Q-1]
//   done     : strobe, dout valid this cycle (3 cycles after start)
//   dout     : result in [0, Q-1], bits [15:14] always 0
module poly_sub_coeff
  import poly_sub_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dia,
  input  logic [15:0] dib,
  output logic        done,
  output logic [15:0] dout
);

  // Stage 0 forms a + 3Q - b (range [2Q, 4Q)); the reduction stages then
  // conditionally remove 2Q and Q, leaving a value in [0, Q).
  localparam int STAGES = 2;

  coeff_wide_t       val_reg  [STAGES+1];
  logic [STAGES:0]   vld_reg;
  coeff_wide_t       red_next [STAGES];

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_red
      localparam coeff_wide_t K = coeff_wide_t'(NEWHOPE_Q << (STAGES - 1 - gi));
      assign red_next[gi] = cond_sub(val_reg[gi], K);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s <= STAGES; s++) begin
        val_reg[s] <= '0;
      end
      vld_reg <= '0;
    end else begin
      val_reg[0] <= {1'b0, dia} + coeff_wide_t'(OFFSET_3Q) - {1'b0, dib};
      vld_reg[0] <= start;
      for (int s = 0; s < STAGES; s++) begin
        val_reg[s+1] <= red_next[s];
        vld_reg[s+1] <= vld_reg[s];
      end
    end
  end

  assign done = vld_reg[STAGES];
  assign dout = {2'b00, val_reg[STAGES][13:0]};

  // Fully reduced value is below Q < 2^14; upper bits are always zero.
  logic unused_hi;
  assign unused_hi = |val_reg[STAGES][CW-1:14];

endmodule

// File: rtl/poly_sub_ctrl.sv
// poly_sub_ctrl: sequences r = a - b (mod Q) over N coefficients.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : one-cycle pulse, accepted only in IDLE
//   busy      : high in READ and DRAIN
//   done      : one-cycle pulse after the last result is written
//   rd_en     : read strobe for source memories A and B
//   rd_addr   : shared read index for A and B
//   dia, dib  : A/B read data, valid one cycle after rd_en
//   wr_en     : result memory write strobe
//   wr_addr   : result index
//   dout      : result coefficient
module poly_sub_ctrl
  import poly_sub_ctrl_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [15:0]   dia,
  input  logic [15:0]   dib,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   dout
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  state_t        state_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          rd_en_reg;
  logic [AW-1:0] rd_cnt_reg;
  logic          sub_start_reg;
  logic          wr_en_reg;
  logic [AW-1:0] wr_addr_reg;
  logic [AW-1:0] wr_cnt_reg;
  logic [15:0]   dout_reg;

  logic          sub_done;
  logic [15:0]   sub_dout;

  poly_sub_coeff u_coeff (
    .clk   (clk),
    .rst   (rst),
    .start (sub_start_reg),
    .dia   (dia),
    .dib   (dib),
    .done  (sub_done),
    .dout  (sub_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      rd_en_reg     <= 1'b0;
      rd_cnt_reg    <= '0;
      sub_start_reg <= 1'b0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_cnt_reg    <= '0;
      dout_reg      <= '0;
    end else begin
      // Source data arrives one cycle after rd_en; hand it over then.
      sub_start_reg <= rd_en_reg;
      wr_en_reg     <= 1'b0;
      done_reg      <= 1'b0;

      // Writes follow the subtractor strobe rather than a fixed delay.
      if (sub_done && busy_reg) begin
        wr_en_reg   <= 1'b1;
        wr_addr_reg <= wr_cnt_reg;
        dout_reg    <= sub_dout;
        wr_cnt_reg  <= wr_cnt_reg + 1'b1;
      end

      unique case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg  <= ST_READ;
            busy_reg   <= 1'b1;
            rd_en_reg  <= 1'b1;
            rd_cnt_reg <= '0;
            wr_cnt_reg <= '0;
          end
        end
        ST_READ: begin
          if (rd_cnt_reg == LAST_IDX) begin
            state_reg  <= ST_DRAIN;
            rd_en_reg  <= 1'b0;
            rd_cnt_reg <= '0;
          end else begin
            rd_cnt_reg <= rd_cnt_reg + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (wr_en_reg && (wr_addr_reg == LAST_IDX)) begin
            state_reg <= ST_FIN;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        ST_FIN: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign rd_en   = rd_en_reg;
  assign rd_addr = rd_cnt_reg;
  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign dout    = dout_reg;

endmodule

// File: tb/tb_poly_sub_ctrl.sv
// Self-checking bench for poly_sub_ctrl: memory models for A and B, a write
// collector, and a modular-arithmetic reference model.
module tb_poly_sub_ctrl;

  localparam int N  = 1024;
  localparam int AW = 10;
  localparam int Q  = 12289;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [15:0]   dia;
  logic [15:0]   dib;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   dout;

  poly_sub_ctrl #(.N(N), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .dia     (dia),
    .dib     (dib),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .dout    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          mem_a [N];
  int          mem_b [N];
  logic [15:0] exp_r [N];

  logic [AW-1:0] wa_q [$];
  logic [15:0]   wd_q [$];
  int            done_cnt = 0;
  int            rd_cnt   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Source memories with registered read.
  always @(posedge clk) begin
    if (rd_en) begin
      dia <= 16'(mem_a[rd_addr]);
      dib <= 16'(mem_b[rd_addr]);
    end
  end

  // Collector samples outputs shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(dout);
    end
    if (done === 1'b1) done_cnt++;
    if (rd_en === 1'b1) rd_cnt++;
  end

  function automatic int ref_sub(input int a, input int b);
    return ((a - b) % Q + Q) % Q;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: begin mem_a[i] = 0;               mem_b[i] = 0;               end
        1: begin mem_a[i] = i % Q;           mem_b[i] = i % Q;           end
        2: begin mem_a[i] = 0;               mem_b[i] = Q - 1;           end
        3: begin mem_a[i] = Q - 1;           mem_b[i] = 0;               end
        default: begin
          mem_a[i] = int'($urandom_range(Q - 1, 0));
          mem_b[i] = int'($urandom_range(Q - 1, 0));
        end
      endcase
      exp_r[i] = 16'(ref_sub(mem_a[i], mem_b[i]));
    end
  endtask

  int t0;
  int extra_starts;

  task automatic start_pass();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    rd_cnt   = 0;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int fin_poke, output int lat);
    int found;
    found = 0;
    for (int k = 0; k < N + 64; k++) begin
      @(negedge clk);
      if (extra_starts != 0 && ((cyc - t0) == 10 || (cyc - t0) == 600))
        start = 1'b1;
      else
        start = 1'b0;
      if (done === 1'b1) begin
        found = 1;
        break;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(found), 32'd1);
    chk("busy_low_at_done", 32'(busy), 32'd0);
    lat = cyc - t0;
    chk("latency_bound", 32'(lat <= N + 10), 32'd1);
    if (fin_poke != 0) begin
      // start during FIN must not restart the block
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("fin_start_ignored_busy", 32'(busy), 32'd0);
      chk("fin_start_ignored_rd_en", 32'(rd_en), 32'd0);
    end
  endtask

  task automatic check_pass(input string tag);
    int bad_a;
    int bad_d;
    bad_a = 0;
    bad_d = 0;
    chk({tag, "_write_count"}, 32'(wa_q.size()), 32'(N));
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_read_count"}, 32'(rd_cnt), 32'(N));
    for (int i = 0; i < wa_q.size() && i < N; i++) begin
      if (wa_q[i] !== AW'(i)) begin
        if (bad_a == 0) chk({tag, "_first_bad_addr"}, 32'(wa_q[i]), 32'(i));
        bad_a++;
      end
      if (wd_q[i] !== exp_r[i]) begin
        if (bad_d == 0) chk({tag, "_first_bad_dout"}, 32'(wd_q[i]), 32'(exp_r[i]));
        bad_d++;
      end
    end
    chk({tag, "_addr_errors"}, 32'(bad_a), 32'd0);
    chk({tag, "_dout_errors"}, 32'(bad_d), 32'd0);
    $display("pass %s: %0d writes, %0d done, addr errors %0d, dout errors %0d",
             tag, wa_q.size(), done_cnt, bad_a, bad_d);
  endtask

  initial begin
    int lat;
    int lat_ref;
    int lat2;
    int found;
    int wq_at_rst;

    rst          = 1'b1;
    start        = 1'b0;
    extra_starts = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_rd_en",   32'(rd_en),   32'd0);
    chk("rst_wr_en",   32'(wr_en),   32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_dout",    32'(dout),    32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // all zeros
    fill(0);
    start_pass();
    wait_done(0, lat_ref);
    repeat (5) @(negedge clk);
    check_pass("zeros");

    // A == B -> 0, with a start poke in the FIN cycle
    fill(1);
    start_pass();
    wait_done(1, lat);
    repeat (5) @(negedge clk);
    check_pass("equal");

    fill(2);
    start_pass();
    wait_done(0, lat);
    repeat (5) @(negedge clk);
    check_pass("a0_bmax");

    fill(3);
    start_pass();
    wait_done(0, lat);
    repeat (5) @(negedge clk);
    check_pass("amax_b0");

    // random with extra starts while busy
    fill(4);
    extra_starts = 1;
    start_pass();
    wait_done(0, lat);
    extra_starts = 0;
    repeat (5) @(negedge clk);
    check_pass("rand_restart");
    chk("rand_restart_latency", 32'(lat), 32'(lat_ref));

    // reset after write index 500
    fill(4);
    start_pass();
    found = 0;
    for (int k = 0; k < N + 64; k++) begin
      @(negedge clk);
      if (wr_en === 1'b1 && wr_addr === AW'(500)) begin
        found = 1;
        break;
      end
    end
    chk("reached_write_500", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_busy",  32'(busy),  32'd0);
    chk("midrst_done",  32'(done),  32'd0);
    chk("midrst_rd_en", 32'(rd_en), 32'd0);
    wq_at_rst = wa_q.size();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_more_writes", 32'(wa_q.size()), 32'(wq_at_rst));
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    chk("midrst_idle_busy", 32'(busy), 32'd0);
    $display("reset mid-pass: %0d writes before reset", wq_at_rst);

    fill(4);
    start_pass();
    wait_done(0, lat);
    repeat (5) @(negedge clk);
    check_pass("after_rst");

    // back-to-back: second start in the cycle after done
    fill(4);
    start_pass();
    wait_done(0, lat);
    check_pass("b2b_first");
    chk("b2b_first_latency", 32'(lat), 32'(lat_ref));
    fill(4);
    start_pass();
    wait_done(0, lat2);
    repeat (5) @(negedge clk);
    check_pass("b2b_second");
    chk("b2b_latency_equal", 32'(lat2), 32'(lat));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global watchdog keeps the run bounded.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
